mem_channel_arbiter: RTL

MEM_CHANNEL_ARBITER -- requirements
Module: mem_channel_arbiter

---
 rtl/mem_pkg.sv | 17 +
 rtl/rr_picker.sv | 31 +++
 rtl/mem_channel_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory channel arbiter: per-channel FSM encoding
// and a helper for sizing consumer index fields.
package mem_pkg;

  typedef enum logic [1:0] {
    CH_IDLE       = 2'd0,
    CH_READ_WAIT  = 2'd1,
    CH_WRITE_WAIT = 2'd2,
    CH_RELAY      = 2'd3
  } ch_state_e;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker: grants the first requester at or after ptr,
// wrapping around, as a one-hot vector.
module rr_picker #(
  parameter int WIDTH    = 8,
  parameter int PTR_BITS = 3
) (
  input  logic [WIDTH-1:0]    req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [WIDTH-1:0]    grant
);

  int   pos;
  logic found;

  // NOTE: every combinational output gets a default before the loop so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int off = 0; off < WIDTH; off++) begin
      pos = int'(ptr) + off;
      if (pos >= WIDTH) pos = pos - WIDTH;
      if (!found && req[pos[PTR_BITS-1:0]]) begin
        grant[pos[PTR_BITS-1:0]] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS requesters with
// round-robin arbitration; each channel carries one transaction at a time.
module mem_channel_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int PTR_BITS = idx_bits(NUM_CONSUMERS);
  typedef logic [PTR_BITS-1:0] idx_t;

  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] rd_addr_in, wr_addr_in;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] wr_data_in, rdata_q;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_rdata_in, mem_wdata_q;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_raddr_q, mem_waddr_q;
  logic [NUM_CHANNELS-1:0]                 rvalid_q, wvalid_q;

  ch_state_e state_q [NUM_CHANNELS];
  ch_state_e state_d [NUM_CHANNELS];
  idx_t      owner_q [NUM_CHANNELS];
  idx_t      rr_ptr_q, rr_ptr_d;

  logic [NUM_CONSUMERS-1:0] busy_q, ready_q, eligible, write_req;
  logic [NUM_CONSUMERS-1:0] avail     [NUM_CHANNELS+1];
  logic [NUM_CONSUMERS-1:0] pick_req  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] grant_vec [NUM_CHANNELS];
  idx_t                     grant_idx [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  grant_any, grant_read, release_owner;

  assign rd_addr_in   = consumer_read_address;
  assign wr_addr_in   = consumer_write_address;
  assign wr_data_in   = consumer_write_data;
  assign mem_rdata_in = mem_read_data;

  // Write-only requests never qualify in read-only mode.
  assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
  assign eligible  = (consumer_read_valid | write_req) & ~busy_q;
  assign avail[0]  = eligible;

  // Each IDLE channel picks from whatever earlier channels left unclaimed,
  // so the k-th idle channel lands on the k-th eligible consumer.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    assign pick_req[ch]  = (state_q[ch] == CH_IDLE) ? avail[ch] : '0;
    assign avail[ch+1]   = avail[ch] & ~grant_vec[ch];
    assign grant_any[ch] = |grant_vec[ch];

    rr_picker #(
      .WIDTH    (NUM_CONSUMERS),
      .PTR_BITS (PTR_BITS)
    ) u_pick (
      .req   (pick_req[ch]),
      .ptr   (rr_ptr_q),
      .grant (grant_vec[ch])
    );
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      grant_idx[ch] = '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        if (grant_vec[ch][i]) grant_idx[ch] = idx_t'(i);
      end
      grant_read[ch]    = consumer_read_valid[grant_idx[ch]];
      release_owner[ch] = !consumer_read_valid[owner_q[ch]] &&
                          !consumer_write_valid[owner_q[ch]];
      // Later channels hold later consumers in rotation order.
      if (grant_any[ch]) begin
        rr_ptr_d = (int'(grant_idx[ch]) == NUM_CONSUMERS - 1) ? '0
                 : grant_idx[ch] + idx_t'(1);
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      case (state_q[ch])
        CH_IDLE:       if (grant_any[ch])
                         state_d[ch] = grant_read[ch] ? CH_READ_WAIT : CH_WRITE_WAIT;
        CH_READ_WAIT:  if (mem_read_ready[ch])  state_d[ch] = CH_RELAY;
        CH_WRITE_WAIT: if (mem_write_ready[ch]) state_d[ch] = CH_RELAY;
        CH_RELAY:      if (release_owner[ch])   state_d[ch] = CH_IDLE;
        default:       state_d[ch] = CH_IDLE;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= CH_IDLE;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= state_d[ch];
    end
  end

  // NOTE: the returned-data array is reset along with the control state
  // because consumers can observe it directly right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      ready_q     <= '0;
      rr_ptr_q    <= '0;
      rdata_q     <= '0;
      rvalid_q    <= '0;
      wvalid_q    <= '0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) owner_q[ch] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (state_q[ch])
          CH_IDLE: if (grant_any[ch]) begin
            owner_q[ch]             <= grant_idx[ch];
            busy_q[grant_idx[ch]]   <= 1'b1;
            if (grant_read[ch]) begin
              rvalid_q[ch]    <= 1'b1;
              mem_raddr_q[ch] <= rd_addr_in[grant_idx[ch]];
            end else begin
              wvalid_q[ch]    <= 1'b1;
              mem_waddr_q[ch] <= wr_addr_in[grant_idx[ch]];
              mem_wdata_q[ch] <= wr_data_in[grant_idx[ch]];
            end
          end
          CH_READ_WAIT: if (mem_read_ready[ch]) begin
            rvalid_q[ch]         <= 1'b0;
            rdata_q[owner_q[ch]] <= mem_rdata_in[ch];
            ready_q[owner_q[ch]] <= 1'b1;
          end
          CH_WRITE_WAIT: if (mem_write_ready[ch]) begin
            wvalid_q[ch]         <= 1'b0;
            ready_q[owner_q[ch]] <= 1'b1;
          end
          CH_RELAY: if (release_owner[ch]) begin
            ready_q[owner_q[ch]] <= 1'b0;
            busy_q[owner_q[ch]]  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign consumer_ready     = ready_q;
  assign consumer_read_data = rdata_q;
  assign mem_read_valid     = rvalid_q;
  assign mem_read_address   = mem_raddr_q;
  assign mem_write_valid    = (WRITE_ENABLE != 0) ? wvalid_q    : '0;
  assign mem_write_address  = (WRITE_ENABLE != 0) ? mem_waddr_q : '0;
  assign mem_write_data     = (WRITE_ENABLE != 0) ? mem_wdata_q : '0;

endmodule
